// File: rtl/mips_mem_pkg.sv
// Shared definitions for the Mips core memory port and the SRAM bridge.
package mips_mem_pkg;

   // SRAM geometry defaults: 2^18 halfwords, 16-bit data bus.
   localparam int SRAM_AW_DEF = 18;
   localparam int SRAM_DW_DEF = 16;

   // Width of the strobe wait-state counter (supports WAIT_CYCLES 0..15).
   localparam int WAIT_W = 4;

   // Active-low control levels.
   localparam logic ASSERT_N   = 1'b0;
   localparam logic DEASSERT_N = 1'b1;

   // Bridge sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LO_ADDR,
      ST_LO_STROBE,
      ST_HI_ADDR,
      ST_HI_STROBE,
      ST_DONE
   } bridge_state_t;

   // Byte enables for one halfword lane: {odd, even}.
   function automatic logic [1:0] lane_enables(input logic [3:0] be, input logic hi);
      return hi ? be[3:2] : be[1:0];
   endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times the SRAM strobe phase.
module sram_wait_counter
   import mips_mem_pkg::*;
#(
   parameter int WIDTH = WAIT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   // Load on request, otherwise count down to zero and stay there.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/sram_bridge.sv
// Bridges the core's 32-bit memory port onto a 16-bit asynchronous SRAM,
// issuing two halfword cycles (low half first) per access.
module sram_bridge
   import mips_mem_pkg::*;
#(
   parameter int SRAM_AW     = SRAM_AW_DEF,
   parameter int SRAM_DW     = SRAM_DW_DEF,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 mem_req,
   input  logic                 mem_we,
   input  logic [31:0]          mem_addr,
   input  logic [31:0]          mem_wdata,
   input  logic [3:0]           mem_be,
   output logic [31:0]          mem_rdata,
   output logic                 mem_ready,
   output logic                 mem_busy,
   output logic [SRAM_AW-1:0]   addr,
   inout  wire logic [SRAM_DW-1:0] data,
   output logic                 wre,
   output logic                 oute,
   output logic                 hb_mask,
   output logic                 lb_mask,
   output logic                 chip_en
);

   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

   bridge_state_t            state;
   bridge_state_t            state_nx;
   logic                     we_q;
   logic [SRAM_AW-2:0]       haddr_q;
   logic [2*SRAM_DW-1:0]     wdata_q;
   logic [3:0]               be_q;
   logic [SRAM_DW-1:0]       lo_q;
   logic                     hi_half;
   logic                     in_addr;
   logic                     in_strobe;
   logic                     active;
   logic [1:0]               half_be;
   logic [SRAM_DW-1:0]       half_wd;
   logic                     wait_expired;
   logic                     unused_addr_bits;

   assign unused_addr_bits = ^{mem_addr[31:SRAM_AW+1], mem_addr[1:0]};

   assign hi_half   = (state == ST_HI_ADDR) || (state == ST_HI_STROBE);
   assign in_addr   = (state == ST_LO_ADDR) || (state == ST_HI_ADDR);
   assign in_strobe = (state == ST_LO_STROBE) || (state == ST_HI_STROBE);
   assign active    = in_addr || in_strobe;
   assign half_be   = lane_enables(be_q, hi_half);
   assign half_wd   = hi_half ? wdata_q[2*SRAM_DW-1:SRAM_DW] : wdata_q[SRAM_DW-1:0];

   assign addr     = {haddr_q, hi_half};
   assign mem_busy = (state != ST_IDLE);

   // Bus is driven only while a write half is in progress; decoded straight
   // from state so an asynchronous reset releases it immediately.
   assign data = (active && we_q) ? half_wd : 'z;

   sram_wait_counter #(
      .WIDTH (WAIT_W)
   ) u_wait (
      .clock      (clock),
      .reset      (reset),
      .load       (in_addr),
      .load_value (WAIT_LOAD),
      .dec        (in_strobe),
      .expired    (wait_expired)
   );

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Capture the request; only looked at while idle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         we_q    <= 1'b0;
         haddr_q <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if ((state == ST_IDLE) && mem_req) begin
         we_q    <= mem_we;
         haddr_q <= mem_addr[SRAM_AW:2];
         wdata_q <= mem_wdata;
         be_q    <= mem_be;
      end
   end

   // Sample read halves on the final strobe cycle; the assembled word lands
   // as DONE is entered and holds until the next read completes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lo_q      <= '0;
         mem_rdata <= '0;
      end else if (!we_q && wait_expired) begin
         if (state == ST_LO_STROBE) begin
            lo_q <= data;
         end else if (state == ST_HI_STROBE) begin
            mem_rdata <= {data, lo_q};
         end
      end
   end

   // Next-state sequencing and SRAM strobe decode.
   always_comb begin
      state_nx  = state;
      mem_ready = 1'b0;
      chip_en   = DEASSERT_N;
      wre       = DEASSERT_N;
      oute      = DEASSERT_N;
      hb_mask   = DEASSERT_N;
      lb_mask   = DEASSERT_N;

      case (state)
         ST_IDLE:      if (mem_req) state_nx = ST_LO_ADDR;
         ST_LO_ADDR:   state_nx = ST_LO_STROBE;
         ST_LO_STROBE: if (wait_expired) state_nx = ST_HI_ADDR;
         ST_HI_ADDR:   state_nx = ST_HI_STROBE;
         ST_HI_STROBE: if (wait_expired) state_nx = ST_DONE;
         ST_DONE: begin
            mem_ready = 1'b1;
            state_nx  = ST_IDLE;
         end
         default:      state_nx = ST_IDLE;
      endcase

      if (active) begin
         if (we_q) begin
            // A write half with no enabled bytes leaves the chip deselected.
            chip_en = (half_be == 2'b00) ? DEASSERT_N : ASSERT_N;
            lb_mask = ~half_be[0];
            hb_mask = ~half_be[1];
            if (in_strobe) wre = ASSERT_N;
         end else begin
            chip_en = ASSERT_N;
            oute    = ASSERT_N;
            lb_mask = ASSERT_N;
            hb_mask = ASSERT_N;
         end
      end
   end

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge: two instances (no wait states and two wait
// states), each attached to a simple asynchronous SRAM model.
module tb_sram_bridge;

   typedef struct packed {
      logic        busy;
      logic        ready;
      logic        ce;
      logic        wre;
      logic        oe;
      logic        hb;
      logic        lb;
      logic [17:0] addr;
      logic [31:0] rdata;
      logic [15:0] data;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0;
   logic        req2 = 1'b0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_be = '0;

   logic [31:0] rdata0, rdata2;
   logic        ready0, ready2, busy0, busy2;
   logic [17:0] addr0, addr2;
   logic        wre0, oe0, hb0, lb0, ce0;
   logic        wre2, oe2, hb2, lb2, ce2;
   wire  [15:0] data0;
   wire  [15:0] data2;

   logic [15:0] ram0 [0:1023];
   logic [15:0] ram2 [0:1023];

   int          ncmp = 0;
   int          nfail = 0;
   logic [31:0] sb [$];

   always #5 clk = ~clk;

   pullup pu_data0 (data0);
   pullup pu_data2 (data2);

   sram_bridge #(.SRAM_AW(18), .SRAM_DW(16), .WAIT_CYCLES(0)) dut0 (
      .clock(clk), .reset(reset), .mem_req(req0), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(rdata0), .mem_ready(ready0), .mem_busy(busy0),
      .addr(addr0), .data(data0), .wre(wre0), .oute(oe0),
      .hb_mask(hb0), .lb_mask(lb0), .chip_en(ce0)
   );

   sram_bridge #(.SRAM_AW(18), .SRAM_DW(16), .WAIT_CYCLES(2)) dut2 (
      .clock(clk), .reset(reset), .mem_req(req2), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rdata(rdata2), .mem_ready(ready2), .mem_busy(busy2),
      .addr(addr2), .data(data2), .wre(wre2), .oute(oe2),
      .hb_mask(hb2), .lb_mask(lb2), .chip_en(ce2)
   );

   // SRAM models: drive on read, byte-masked write while wre is low.
   assign data0 = (!ce0 && !oe0 && wre0) ? ram0[addr0[9:0]] : 16'hzzzz;
   assign data2 = (!ce2 && !oe2 && wre2) ? ram2[addr2[9:0]] : 16'hzzzz;

   always @(negedge clk) begin
      if (!ce0 && !wre0) begin
         if (!lb0) ram0[addr0[9:0]][7:0]  <= data0[7:0];
         if (!hb0) ram0[addr0[9:0]][15:8] <= data0[15:8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic obs_t sample(input int w);
      obs_t o;
      if (w == 0) begin
         o = '{busy0, ready0, ce0, wre0, oe0, hb0, lb0, addr0, rdata0, data0};
      end else begin
         o = '{busy2, ready2, ce2, wre2, oe2, hb2, lb2, addr2, rdata2, data2};
      end
      return o;
   endfunction

   task automatic set_req(input int w, input logic v);
      if (w == 0) req0 = v;
      else        req2 = v;
   endtask

   task automatic check_released(input int w, input string tag);
      obs_t o;
      o = sample(w);
      chk({tag, "_ce"},   32'(o.ce),   32'd1);
      chk({tag, "_wre"},  32'(o.wre),  32'd1);
      chk({tag, "_oe"},   32'(o.oe),   32'd1);
      chk({tag, "_hb"},   32'(o.hb),   32'd1);
      chk({tag, "_lb"},   32'(o.lb),   32'd1);
      chk({tag, "_data"}, 32'(o.data), 32'h0000_ffff);
      chk({tag, "_busy"}, 32'(o.busy), 32'd0);
      chk({tag, "_rdy"},  32'(o.ready), 32'd0);
   endtask

   // One access on instance w (0: no wait states, else two). Checks every
   // cycle's strobes against the expected phase. abort_k>0 asserts reset
   // mid-cycle in that cycle; poke pulses mem_req while busy.
   task automatic do_access(input int w, input string tn, input logic we,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input logic [31:0] exp_rd,
                            input int abort_k, input bit poke);
      int          wc;
      int          lat;
      obs_t        o;
      logic        is_addr, is_hi, is_done, is_strobe, act;
      logic [1:0]  hbe;
      logic [15:0] hwd;
      logic [31:0] e;
      wc  = (w == 0) ? 0 : 2;
      lat = 5 + 2 * wc;
      mem_we = we; mem_addr = a; mem_wdata = wd; mem_be = be;
      set_req(w, 1'b1);
      if (!we && abort_k == 0) sb.push_back(exp_rd);
      @(posedge clk); #1;
      set_req(w, 1'b0);
      for (int k = 1; k <= lat; k++) begin
         is_addr   = (k == 1) || (k == 3 + wc);
         is_hi     = (k >= 3 + wc);
         is_done   = (k == lat);
         is_strobe = !is_addr && !is_done;
         act       = !is_done;
         hbe       = is_hi ? be[3:2] : be[1:0];
         hwd       = is_hi ? wd[31:16] : wd[15:0];
         o = sample(w);
         chk($sformatf("%s_busy_c%0d", tn, k), 32'(o.busy), 32'd1);
         chk($sformatf("%s_rdy_c%0d", tn, k), 32'(o.ready), 32'(is_done));
         chk($sformatf("%s_ce_c%0d", tn, k), 32'(o.ce),
             32'(act ? (we && hbe == 2'b00) : 1'b1));
         chk($sformatf("%s_wre_c%0d", tn, k), 32'(o.wre),
             32'(!(act && we && is_strobe)));
         chk($sformatf("%s_oe_c%0d", tn, k), 32'(o.oe), 32'(!(act && !we)));
         chk($sformatf("%s_lb_c%0d", tn, k), 32'(o.lb),
             32'(act ? (we ? !hbe[0] : 1'b0) : 1'b1));
         chk($sformatf("%s_hb_c%0d", tn, k), 32'(o.hb),
             32'(act ? (we ? !hbe[1] : 1'b0) : 1'b1));
         chk($sformatf("%s_safe_c%0d", tn, k), 32'(!o.oe && !o.wre), 32'd0);
         if (act) begin
            chk($sformatf("%s_addr_c%0d", tn, k), 32'(o.addr), 32'({a[18:2], is_hi}));
         end
         if (act && we) begin
            chk($sformatf("%s_data_c%0d", tn, k), 32'(o.data), 32'(hwd));
         end else if (is_done) begin
            chk($sformatf("%s_data_c%0d", tn, k), 32'(o.data), 32'h0000_ffff);
         end
         if (o.ready && !we) begin
            if (sb.size() == 0) begin
               chk({tn, "_sb_unexpected"}, 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk({tn, "_rdata"}, o.rdata, e);
            end
         end
         if (poke && k == 3) set_req(w, 1'b1);
         if (poke && k == 4) set_req(w, 1'b0);
         if (k == abort_k) begin
            #2 reset = 1'b1;
            #1 check_released(w, {tn, "_rst"});
            o = sample(w);
            chk({tn, "_rst_rdata"}, o.rdata, 32'h0);
            @(posedge clk); #1;
            reset = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      for (int i = 0; i < 3; i++) begin
         o = sample(w);
         chk($sformatf("%s_idle_busy%0d", tn, i), 32'(o.busy), 32'd0);
         chk($sformatf("%s_idle_rdy%0d", tn, i), 32'(o.ready), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram0[i] = 16'h0;
         ram2[i] = 16'h0;
      end
      ram0[10'h020] = 16'h4820;
      ram0[10'h021] = 16'h0000;
      ram0[10'h100] = 16'h1111;
      ram0[10'h101] = 16'h2222;
      ram2[10'h030] = 16'h5678;
      ram2[10'h031] = 16'h1234;

      // Power-up reset state of both instances.
      #1;
      check_released(0, "por0");
      check_released(1, "por2");
      chk("por0_addr", 32'(addr0), 32'h0);
      chk("por0_rdata", rdata0, 32'h0);
      chk("por2_rdata", rdata2, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // T1: reset asserted mid-cycle during the low strobe of a read.
      do_access(0, "t1", 1'b0, 32'h40, 32'h0, 4'hF, 32'h0, 2, 1'b0);

      // T2: plain read.
      do_access(0, "t2", 1'b0, 32'h40, 32'h0, 4'hF, 32'h0000_4820, 0, 1'b0);

      // T3: full-word write then readback.
      do_access(0, "t3w", 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 1'b0);
      chk("t3_ram80", 32'(ram0[10'h080]), 32'h0000_BEEF);
      chk("t3_ram81", 32'(ram0[10'h081]), 32'h0000_DEAD);
      do_access(0, "t3r", 1'b0, 32'h100, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, 1'b0);

      // T4: single-byte write into the high half's lower lane.
      do_access(0, "t4w", 1'b1, 32'h100, 32'h00AB_0000, 4'b0100, 32'h0, 0, 1'b0);
      chk("t4_ram80", 32'(ram0[10'h080]), 32'h0000_BEEF);
      chk("t4_ram81", 32'(ram0[10'h081]), 32'h0000_DEAB);
      do_access(0, "t4r", 1'b0, 32'h100, 32'h0, 4'hF, 32'hDEAB_BEEF, 0, 1'b0);

      // T6: reset in the high-half address cycle of a write, then a read.
      do_access(0, "t6w", 1'b1, 32'h200, 32'h5555_AAAA, 4'hF, 32'h0, 3, 1'b0);
      chk("t6_ram101", 32'(ram0[10'h101]), 32'h0000_2222);
      do_access(0, "t6r", 1'b0, 32'h40, 32'h0, 4'hF, 32'h0000_4820, 0, 1'b0);

      // T5: two wait states, with a request pulsed while busy.
      do_access(1, "t5", 1'b0, 32'h60, 32'h0, 4'hF, 32'h1234_5678, 0, 1'b1);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
